cmp_serial_unit: RTL and testbench

CMP_SERIAL_UNIT -- requirements
Module: cmp_serial_unit

---
 rtl/core_pack_pkg.sv | 37 +++
 rtl/cmp_slice.sv | 17 +
 rtl/cmp_serial_unit.sv | 138 +++++++++++++
 tb/tb_cmp_serial_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pack_pkg.sv
// Shared core types: comparison opcodes, serial-compare FSM states, default sizes
// and the opcode-to-result mapping.
package core_pack_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  localparam int unsigned CMP_WIDTH_DEF = 64;
  localparam int unsigned CMP_SLICE_DEF = 16;

  // Final result from the accumulated difference/less-than flags.
  function automatic logic cmp_result(input cmp_op_enum op, input logic diff, input logic lt);
    logic res;
    res = 1'b0;
    case (op)
      CMP_EQ:           res = !diff;
      CMP_NE:           res = diff;
      CMP_LT, CMP_LTU:  res = lt;
      CMP_GE, CMP_GEU:  res = !lt;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// One-slice magnitude compare: reports inequality and a < b, signed or unsigned.
module cmp_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             is_signed,
  output logic             diff,
  output logic             lt
);

  always_comb begin
    diff = (a != b);
    lt   = is_signed ? ($signed(a) < $signed(b)) : (a < b);
  end

endmodule

// File: rtl/cmp_serial_unit.sv
// Multi-cycle comparator scanning operands MSB slice first, one slice per cycle.
// Optional CMP_EARLY_EXIT_EN finishes as soon as the first differing slice is seen.
module cmp_serial_unit
  import core_pack_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_WIDTH_DEF,
  parameter int unsigned SLICE = CMP_SLICE_DEF,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  cmp_op_enum       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_res,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_cfg
      $error("cmp_serial_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  cmp_state_e state_q, state_d;
  logic [NSLICE-1:0][SLICE-1:0] a_q, b_q;
  cmp_op_enum       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic             diff_found, lt;
  logic             accept, finish;
  logic             slice_signed, slice_diff, slice_lt;
  logic             diff_now, lt_now;

  // Only the top slice carries the sign, and only for signed ops.
  assign slice_signed = (idx_q == TOP_IDX) && ((op_q == CMP_LT) || (op_q == CMP_GE));
  assign diff_now     = diff_found | slice_diff;
  assign lt_now       = diff_found ? lt : slice_lt;

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .a         (a_q[idx_q]),
    .b         (b_q[idx_q]),
    .is_signed (slice_signed),
    .diff      (slice_diff),
    .lt        (slice_lt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid && !flush) state_d = BUSY;
      BUSY: begin
        if (flush)               state_d = IDLE;
        else if (idx_q == '0)    state_d = DONE;
`ifdef CMP_EARLY_EXIT_EN
        else if (slice_diff)     state_d = DONE;
`endif
      end
      DONE: if (flush || resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !flush;
        accept    = req_valid && !flush;
      end
      BUSY: begin
        busy   = 1'b1;
        finish = (state_d == DONE);
      end
      DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, slice walk, first-difference flags and response latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= CMP_EQ;
      tag_q      <= '0;
      idx_q      <= '0;
      diff_found <= 1'b0;
      lt         <= 1'b0;
      resp_res   <= 1'b0;
      resp_tag   <= '0;
    end else begin
      if (accept) begin
        a_q        <= req_a;
        b_q        <= req_b;
        op_q       <= req_op;
        tag_q      <= req_tag;
        idx_q      <= TOP_IDX;
        diff_found <= 1'b0;
        lt         <= 1'b0;
      end else if (state_q == BUSY) begin
        if (!diff_found && slice_diff) begin
          diff_found <= 1'b1;
          lt         <= slice_lt;
        end
        idx_q <= idx_q - IDX_W'(1);
      end
      if (finish) begin
        resp_res <= cmp_result(op_q, diff_now, lt_now);
        resp_tag <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_cmp_serial_unit.sv
// Directed bench for cmp_serial_unit (WIDTH=64, SLICE=16): vector table plus
// flush, reset and back-pressure sequences. Honors CMP_EARLY_EXIT_EN.
module tb_cmp_serial_unit;
  import core_pack_pkg::*;

  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a, req_b;
  cmp_op_enum  req_op;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_res;
  logic [3:0]  resp_tag;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    cmp_op_enum  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic        res;
    int          lat;
    int          lat_ee;
  } vec_t;

  vec_t vecs[NV];

  cmp_serial_unit #(.WIDTH(64), .SLICE(16), .TAG_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_res   (resp_res),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input cmp_op_enum op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag, input string name);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    #1 check({name, " req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic watch_no_resp(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;

    vecs[0]  = '{CMP_EQ,  64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 4'h1, 1'b1, 4, 4};
    vecs[1]  = '{CMP_LT,  64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 4'h2, 1'b1, 4, 1};
    vecs[2]  = '{CMP_LTU, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 4'h3, 1'b0, 4, 1};
    vecs[3]  = '{CMP_LT,  64'h0000000000000000, 64'h7FFFFFFFFFFFFFFF, 4'h4, 1'b1, 4, 1};
    vecs[4]  = '{CMP_GE,  64'h0000000000000000, 64'h7FFFFFFFFFFFFFFF, 4'h5, 1'b0, 4, 1};
    vecs[5]  = '{CMP_GEU, 64'h0000000000000005, 64'h0000000000000003, 4'h6, 1'b1, 4, 4};
    vecs[6]  = '{CMP_NE,  64'h0000000000000005, 64'h0000000000000003, 4'h7, 1'b1, 4, 4};
    vecs[7]  = '{CMP_NE,  64'hDEADBEEF00C0FFEE, 64'hDEADBEEF00C0FFEE, 4'h8, 1'b0, 4, 4};
    vecs[8]  = '{cmp_op_enum'(3'd7), 64'h5, 64'h3, 4'h9, 1'b0, 4, 4};
    vecs[9]  = '{CMP_GE,  64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 4'hB, 1'b0, 4, 1};
    vecs[10] = '{CMP_LTU, 64'h0001000000000000, 64'h0000FFFFFFFFFFFF, 4'hC, 1'b0, 4, 1};
    vecs[11] = '{CMP_LT,  64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 4'hD, 1'b1, 4, 1};
    vecs[12] = '{CMP_LT,  64'h0000000000010000, 64'h000000000000FFFF, 4'hE, 1'b0, 4, 3};
    vecs[13] = '{CMP_GE,  64'h0000000000008000, 64'h0000000000007FFF, 4'hF, 1'b1, 4, 4};
    vecs[14] = '{CMP_LT,  64'hFFFF000000000000, 64'hFFFF000000000001, 4'h0, 1'b1, 4, 4};

    rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_a = '0; req_b = '0; req_op = CMP_EQ; req_tag = '0;

    // Reset state
    #1;
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst busy",       64'(busy),       64'd0);
    check("rst resp_res",   64'(resp_res),   64'd0);
    check("rst resp_tag",   64'(resp_tag),   64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("post-rst req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
`ifdef CMP_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_ee;
`else
      exp_lat = vecs[i].lat;
`endif
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, $sformatf("v%0d", i));
      wait_resp(lat);
      check($sformatf("v%0d res", i), 64'(resp_res), 64'(vecs[i].res));
      check($sformatf("v%0d tag", i), 64'(resp_tag), 64'(vecs[i].tag));
      check($sformatf("v%0d latency", i), 64'(lat), 64'(exp_lat));
    end

    // Flush during the second BUSY cycle
    issue(CMP_GEU, 64'h5, 64'h3, 4'h3, "flush");
    @(posedge clk); @(negedge clk);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush busy",      64'(busy),       64'd0);
    check("flush resp_valid", 64'(resp_valid), 64'd0);
    check("flush req_ready", 64'(req_ready),  64'd1);
    watch_no_resp("flush no resp", 6);

    // Flush coinciding with a request wins
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    #1 check("flush+req req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    #1 check("flush+req busy", 64'(busy), 64'd0);
    req_valid = 1'b0; flush = 1'b0;

    // Reset during the second BUSY cycle
    issue(CMP_GEU, 64'h5, 64'h3, 4'h5, "rst-mid");
    @(posedge clk); @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst-mid busy",       64'(busy),       64'd0);
    check("rst-mid resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 check("rst-mid req_ready", 64'(req_ready), 64'd1);
    watch_no_resp("rst-mid no resp", 6);

    // Response held under back-pressure for three cycles
    resp_ready = 1'b0;
    issue(CMP_LT, 64'hFFFFFFFFFFFFFFFF, 64'h1, 4'hA, "bp");
    wait_resp(lat);
    check("bp valid", 64'(resp_valid), 64'd1);
    check("bp res",   64'(resp_res),   64'd1);
    check("bp tag",   64'(resp_tag),   64'hA);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("bp hold%0d valid", k), 64'(resp_valid), 64'd1);
      check($sformatf("bp hold%0d res", k),   64'(resp_res),   64'd1);
      check($sformatf("bp hold%0d tag", k),   64'(resp_tag),   64'hA);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    check("bp release valid", 64'(resp_valid), 64'd0);
    check("bp release busy",  64'(busy),       64'd0);
    check("bp release ready", 64'(req_ready),  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
